// File: rtl/arm_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package arm_fetch_pkg;

    localparam int IMEM_AW = 7;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h8b1f03ff;

    // Occupancy of the two-entry fetch buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, word} buffer between the ROM and decode.
// The head entry lives directly in the output registers, so the outputs have
// no combinational path from pop. An empty head is held at zero.
//
// state     | meaning
// OCC_EMPTY | no entries, head registers zero
// OCC_ONE   | head valid, tail unused
// OCC_FULL  | head and tail valid
module fetch_fifo import arm_fetch_pkg::*; #(
    parameter int N = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [N-1:0]       push_pc,
    input  logic [INSTR_W-1:0] push_word,
    output logic               full,
    output logic               empty,
    output logic               head_valid,
    output logic [N-1:0]       head_pc,
    output logic [INSTR_W-1:0] head_word
);

    occ_t               occ;
    logic [N-1:0]       tail_pc;
    logic [INSTR_W-1:0] tail_word;

    assign full  = (occ == OCC_FULL);
    assign empty = (occ == OCC_EMPTY);

    // Occupancy FSM; push/pop together keeps occupancy and shifts in order
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ        <= OCC_EMPTY;
            head_valid <= 1'b0;
            head_pc    <= '0;
            head_word  <= '0;
            tail_pc    <= '0;
            tail_word  <= '0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        occ        <= OCC_ONE;
                        head_valid <= 1'b1;
                        head_pc    <= push_pc;
                        head_word  <= push_word;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_pc   <= push_pc;
                        head_word <= push_word;
                    end else if (push) begin
                        occ       <= OCC_FULL;
                        tail_pc   <= push_pc;
                        tail_word <= push_word;
                    end else if (pop) begin
                        occ        <= OCC_EMPTY;
                        head_valid <= 1'b0;
                        head_pc    <= '0;
                        head_word  <= '0;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_pc   <= tail_pc;
                        head_word <= tail_word;
                        if (push) begin
                            tail_pc   <= push_pc;
                            tail_word <= push_word;
                        end else begin
                            occ       <= OCC_ONE;
                            tail_pc   <= '0;
                            tail_word <= '0;
                        end
                    end
                end
                default: begin
                    occ        <= OCC_EMPTY;
                    head_valid <= 1'b0;
                    head_pc    <= '0;
                    head_word  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, redirect handling and the fetch buffer.
// The ROM is combinational, so a word is captured in the same cycle its
// address is presented.
module instr_fetch import arm_fetch_pkg::*; #(
    parameter int          N        = 64,
    parameter int          AW       = IMEM_AW,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [AW-1:0]      imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    input  logic               redirect_valid,
    input  logic [N-1:0]       redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [N-1:0]       instr_pc,
    input  logic               instr_ready
);

    localparam logic [N-1:0] PC_STEP = N'(4);

    logic [N-1:0] fetch_pc;
    logic         fifo_full;
    logic         fifo_empty;
    logic         dequeue;
    logic         push;
    logic         unused_rpc_lo;

    // Redirect targets are forced to word alignment; the low bits are dropped
    assign unused_rpc_lo = ^redirect_pc[1:0];

    assign imem_addr = fetch_pc[AW+1:2];
    assign dequeue   = instr_ready & ~fifo_empty;
    // A pop frees a slot in the same cycle, so a full buffer still streams
    assign push      = ~redirect_valid & (~fifo_full | dequeue);

    // Fetch PC: reset, then redirect, then sequential advance on push
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[N-1:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    fetch_fifo #(.N(N)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (dequeue),
        .push_pc    (fetch_pc),
        .push_word  (imem_q),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_word  (instr)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, a redirect latency sequence,
// then random traffic against a queue-based reference model.
module tb_instr_fetch;

    localparam int N  = 64;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic          redirect_valid;
    logic [N-1:0]  redirect_pc;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [N-1:0]  instr_pc;
    logic          instr_ready;

    logic [31:0] rom [128];

    always #5 clk = ~clk;

    assign imem_q = rom[imem_addr];

    instr_fetch #(.N(N), .AW(AW), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ev;
        logic [63:0] epc;
        logic [6:0]  eaddr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_at(input logic [63:0] pc);
        return rom[pc[8:2]];
    endfunction

    task automatic step(input logic rst, input logic rv, input logic [63:0] rpc, input logic rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [63:0] epc, input logic [6:0] eaddr);
        chk({tag, ".valid"}, 64'(instr_valid), 64'(ev));
        chk({tag, ".pc"},    instr_pc, ev ? epc : 64'h0);
        chk({tag, ".instr"}, 64'(instr), ev ? 64'(rom_at(epc)) : 64'h0);
        chk({tag, ".addr"},  64'(imem_addr), 64'(eaddr));
    endtask

    function automatic vec_t mk(input logic rst, input logic rv, input logic [63:0] rpc,
                                input logic rdy, input logic ev, input logic [63:0] epc,
                                input logic [6:0] eaddr);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        return v;
    endfunction

    vec_t vecs[$];

    // reference model state
    logic [63:0] mq[$];
    logic [63:0] mpc;

    initial begin
        int edges;
        for (int i = 0; i < 128; i++) rom[i] = {8'(i), 24'($urandom)};
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        // rst rv rpc rdy | ev epc addr   (expected after the edge)
        vecs.push_back(mk(1, 0, 0,      1, 0, 0,      0));
        vecs.push_back(mk(1, 0, 0,      1, 0, 0,      0));
        // stream A,B,C,D from reset
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h0,  1));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h4,  2));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h8,  3));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'hC,  4));
        // stall five cycles: fills after two pushes, address holds at 2
        vecs.push_back(mk(1, 0, 0,      0, 0, 0,      0));
        vecs.push_back(mk(0, 0, 0,      0, 1, 64'h0,  1));
        vecs.push_back(mk(0, 0, 0,      0, 1, 64'h0,  2));
        vecs.push_back(mk(0, 0, 0,      0, 1, 64'h0,  2));
        vecs.push_back(mk(0, 0, 0,      0, 1, 64'h0,  2));
        vecs.push_back(mk(0, 0, 0,      0, 1, 64'h0,  2));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h4,  3));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h8,  4));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'hC,  5));
        // redirect while full and stalled
        vecs.push_back(mk(0, 0, 0,      0, 1, 64'hC,  5));
        vecs.push_back(mk(0, 1, 64'h1C, 0, 0, 0,      7));
        vecs.push_back(mk(0, 0, 0,      0, 1, 64'h1C, 8));
        // redirect with a coincident dequeue, unaligned target
        vecs.push_back(mk(0, 1, 64'h43, 1, 0, 0,      16));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h40, 17));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h44, 18));
        // ROM address wrap past 0x1FC
        vecs.push_back(mk(0, 1, 64'h1F8,1, 0, 0,      126));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h1F8,127));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h1FC,0));
        vecs.push_back(mk(0, 0, 0,      1, 1, 64'h200,1));
        // reset beats a simultaneous redirect while one entry is held
        vecs.push_back(mk(1, 1, 64'h80, 1, 0, 0,      0));
        vecs.push_back(mk(0, 0, 0,      0, 1, 64'h0,  1));

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].rv, vecs[k].rpc, vecs[k].rdy);
            check_out($sformatf("vec%0d", k), vecs[k].ev, vecs[k].epc, vecs[k].eaddr);
        end

        // redirect latency: valid must appear one edge after the redirect edge
        step(0, 1, 64'h100, 1);
        edges = 0;
        while (!instr_valid && edges < 4) begin
            step(0, 0, 0, 1);
            edges++;
        end
        chk("redirect_latency", 64'(edges), 64'd1);
        chk("redirect_pc", instr_pc, 64'h100);
        chk("redirect_word", 64'(instr), 64'(rom[64]));

        // random traffic against the queue model
        step(1, 0, 0, 0);
        mq.delete();
        mpc = 64'h0;
        check_out("rnd_reset", 1'b0, 64'h0, 7'd0);
        for (int c = 0; c < 600; c++) begin
            logic        r_rst, r_rv, r_rdy;
            logic [63:0] r_rpc, h;
            r_rst = ($urandom_range(0, 59) == 0);
            r_rv  = ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rpc = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 1023))
                                                : {$urandom, $urandom};
            if (r_rst) begin
                mq.delete();
                mpc = 64'h0;
            end else begin
                if (mq.size() > 0 && r_rdy) void'(mq.pop_front());
                if (r_rv) begin
                    mq.delete();
                    mpc = r_rpc & ~64'h3;
                end else if (mq.size() < 2) begin
                    mq.push_back(mpc);
                    mpc = mpc + 64'd4;
                end
            end
            step(r_rst, r_rv, r_rpc, r_rdy);
            h = (mq.size() > 0) ? mq[0] : 64'h0;
            check_out($sformatf("rnd%0d", c), mq.size() > 0, h, mpc[8:2]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
